// File: rtl/loader_pkg.sv
// loader_pkg: shared states and framing constants for the program loader.
package loader_pkg;
    typedef enum logic [2:0] {I_CNT, I_DATA, D_CNT, D_DATA, RUN, ERR} state_t;
    localparam int COUNT_BYTES = 2;
    localparam int I_BYTES = 4;
    localparam int D_BYTES = 8;
endpackage

// File: rtl/byte_assembler.sv
// byte_assembler: packs an LSB-first byte stream into BYTES-wide words.
module byte_assembler #(
    parameter int BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_byte,
    input  logic                 accept,
    input  logic                 clear,
    output logic [8*BYTES-1:0]   word,
    output logic                 word_done
);
    localparam int IW = $clog2(BYTES);
    logic [IW-1:0]      idx;
    logic [8*BYTES-1:0] buf_q;
    assign word_done = accept && idx == IW'(BYTES - 1);
    // The final byte bypasses the buffer so the word is complete on its accepting edge.
    always_comb begin
        word = buf_q;
        word[8*(BYTES-1) +: 8] = rx_byte;
    end
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx   <= '0;
            buf_q <= '0;
        end else if (accept) begin
            buf_q[{idx, 3'b000} +: 8] <= rx_byte;
            idx <= word_done ? '0 : idx + IW'(1);
        end
    end
endmodule

// File: rtl/cpu_program_loader.sv
// cpu_program_loader: streams an instruction image and a data image into cpu
// memory, then enables the cpu once both have loaded without error.
module cpu_program_loader
    import loader_pkg::*;
#(
    parameter int IMEM_DEPTH  = 512,
    parameter int DMEM_DEPTH  = 1024,
    parameter int IMEM_STRIDE = 4,
    parameter int DMEM_STRIDE = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic [31:0] wdata_ext,
    output logic        ren_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        ren_ext_2,
    output logic        cpu_enable,
    output logic        error
);
    state_t      state, state_n;
    logic        accept, in_cnt, cnt_done, last_word, i_done, d_done, cb;
    logic [7:0]  cnt_lo;
    logic [16:0] cnt_n, total, widx;
    logic [31:0] i_word;
    logic [63:0] d_word;
    assign rx_ready  = state inside {I_CNT, I_DATA, D_CNT, D_DATA};
    assign accept    = rx_valid && rx_ready;
    assign in_cnt    = state == I_CNT || state == D_CNT;
    assign cnt_n     = {1'b0, rx_data, cnt_lo};
    assign cnt_done  = accept && in_cnt && cb == 1'(COUNT_BYTES - 1);
    assign last_word = widx == total - 17'd1;
    assign ren_ext   = 1'b0;
    assign ren_ext_2 = 1'b0;
    byte_assembler #(.BYTES(I_BYTES)) u_iasm (
        .clk(clk), .rst(rst), .rx_byte(rx_data),
        .accept(accept && state == I_DATA), .clear(state != I_DATA),
        .word(i_word), .word_done(i_done)
    );
    byte_assembler #(.BYTES(D_BYTES)) u_dasm (
        .clk(clk), .rst(rst), .rx_byte(rx_data),
        .accept(accept && state == D_DATA), .clear(state != D_DATA),
        .word(d_word), .word_done(d_done)
    );
    always_comb begin
        state_n = state;
        case (state)
            I_CNT:  if (cnt_done) state_n = cnt_n == 17'd0 ? D_CNT :
                                            cnt_n > 17'(IMEM_DEPTH) ? ERR : I_DATA;
            I_DATA: if (i_done && last_word) state_n = D_CNT;
            D_CNT:  if (cnt_done) state_n = cnt_n == 17'd0 ? RUN :
                                            cnt_n > 17'(DMEM_DEPTH) ? ERR : D_DATA;
            D_DATA: if (d_done && last_word) state_n = RUN;
            default: state_n = state;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= I_CNT;
            cb          <= 1'b0;
            cnt_lo      <= '0;
            total       <= '0;
            widx        <= '0;
            addr_ext    <= '0;
            wen_ext     <= 1'b0;
            wdata_ext   <= '0;
            addr_ext_2  <= '0;
            wen_ext_2   <= 1'b0;
            wdata_ext_2 <= '0;
            cpu_enable  <= 1'b0;
            error       <= 1'b0;
        end else begin
            state      <= state_n;
            wen_ext    <= i_done;
            wen_ext_2  <= d_done;
            cpu_enable <= state == RUN;
            error      <= state_n == ERR;
            if (accept && in_cnt) begin
                cb     <= ~cb;
                cnt_lo <= rx_data;
            end
            // The word index restarts for each image once its count is known.
            if (cnt_done) begin
                total <= cnt_n;
                widx  <= '0;
            end else if (i_done || d_done) begin
                widx <= widx + 17'd1;
            end
            if (i_done) begin
                addr_ext  <= 64'(widx) * 64'(IMEM_STRIDE);
                wdata_ext <= i_word;
            end
            if (d_done) begin
                addr_ext_2  <= 64'(widx) * 64'(DMEM_STRIDE);
                wdata_ext_2 <= d_word;
            end
        end
    end
endmodule

// File: tb/tb_cpu_program_loader.sv
// tb_cpu_program_loader: drives random images through the loader and checks
// the memory writes against the images that were streamed.
module tb_cpu_program_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
    logic [31:0] wdata_ext;
    logic        wen_ext, wen_ext_2, ren_ext, ren_ext_2, cpu_enable, error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int en_cyc = -1;
    bit overlap = 0;
    bit en_strobe = 0;
    logic [63:0] ia_q[$], id_q[$], da_q[$], dd_q[$];
    logic [31:0] imem_img[$];
    logic [63:0] dmem_img[$];

    cpu_program_loader dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .wdata_ext(wdata_ext), .ren_ext(ren_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .wdata_ext_2(wdata_ext_2),
        .ren_ext_2(ren_ext_2), .cpu_enable(cpu_enable), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wen_ext) begin
            ia_q.push_back(addr_ext);
            id_q.push_back({32'b0, wdata_ext});
        end
        if (wen_ext_2) begin
            da_q.push_back(addr_ext_2);
            dd_q.push_back(wdata_ext_2);
        end
        if (wen_ext && wen_ext_2) overlap = 1;
        if (cpu_enable && (wen_ext || wen_ext_2)) en_strobe = 1;
        if (cpu_enable && en_cyc < 0) en_cyc = cyc;
    end

    task automatic clear_obs();
        ia_q.delete(); id_q.delete(); da_q.delete(); dd_q.delete();
        overlap = 0; en_strobe = 0; en_cyc = -1;
    endtask

    task automatic do_reset();
        rx_valid = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        clear_obs();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        if (gap > 0) begin
            rx_valid = 0;
            repeat (gap) @(negedge clk);
        end
        rx_data = b;
        rx_valid = 1;
        while (!rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!rx_ready) begin
            errors++;
            $display("FAIL byte_accept: rx_ready=%0b required 1", rx_ready);
            rx_valid = 0;
        end else begin
            @(negedge clk);
            last_acc = cyc;
        end
    endtask

    task automatic send_count(input int n, input int maxgap);
        logic [15:0] v;
        v = 16'(n);
        send_byte(v[7:0], int'($urandom_range(maxgap, 0)));
        send_byte(v[15:8], int'($urandom_range(maxgap, 0)));
    endtask

    task automatic load_and_check(input int maxgap, input string name);
        send_count(imem_img.size(), maxgap);
        foreach (imem_img[i]) begin
            logic [31:0] w;
            w = imem_img[i];
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], int'($urandom_range(maxgap, 0)));
        end
        send_count(dmem_img.size(), maxgap);
        foreach (dmem_img[i]) begin
            logic [63:0] d;
            d = dmem_img[i];
            for (int k = 0; k < 8; k++) send_byte(d[8*k +: 8], int'($urandom_range(maxgap, 0)));
        end
        rx_valid = 0;
        for (int t = 0; t < 20 && !cpu_enable; t++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (cpu_enable !== 1'b1) begin
            errors++;
            $display("FAIL %s cpu_enable: got %0b required 1", name, cpu_enable);
        end
        checks++;
        if (en_cyc - last_acc !== 1) begin
            errors++;
            $display("FAIL %s enable_latency: got %0d edges required 1", name, en_cyc - last_acc);
        end
        checks++;
        if (ia_q.size() !== imem_img.size() || da_q.size() !== dmem_img.size()) begin
            errors++;
            $display("FAIL %s write_count: got i=%0d d=%0d required i=%0d d=%0d",
                     name, ia_q.size(), da_q.size(), imem_img.size(), dmem_img.size());
        end
        foreach (imem_img[i]) if (i < ia_q.size()) begin
            checks++;
            if (ia_q[i] !== 64'(i * 4) || id_q[i] !== {32'b0, imem_img[i]}) begin
                errors++;
                $display("FAIL %s imem[%0d]: got addr=%h data=%h required addr=%h data=%h",
                         name, i, ia_q[i], id_q[i], 64'(i * 4), imem_img[i]);
            end
        end
        foreach (dmem_img[i]) if (i < da_q.size()) begin
            checks++;
            if (da_q[i] !== 64'(i * 8) || dd_q[i] !== dmem_img[i]) begin
                errors++;
                $display("FAIL %s dmem[%0d]: got addr=%h data=%h required addr=%h data=%h",
                         name, i, da_q[i], dd_q[i], 64'(i * 8), dmem_img[i]);
            end
        end
        checks++;
        if (overlap || en_strobe || error) begin
            errors++;
            $display("FAIL %s exclusivity: got overlap=%0b en_strobe=%0b error=%0b required 0 0 0",
                     name, overlap, en_strobe, error);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({wen_ext, wen_ext_2, cpu_enable, error, ren_ext, ren_ext_2} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {wen_ext, wen_ext_2, cpu_enable, error, ren_ext, ren_ext_2});
        end
        checks++;
        if (addr_ext !== 64'b0 || addr_ext_2 !== 64'b0) begin
            errors++;
            $display("FAIL reset_addr: got %h %h required 0 0", addr_ext, addr_ext_2);
        end
        checks++;
        if (wdata_ext !== 32'b0 || wdata_ext_2 !== 64'b0) begin
            errors++;
            $display("FAIL reset_data: got %h %h required 0 0", wdata_ext, wdata_ext_2);
        end
    endtask

    task automatic test_instr_only();
        do_reset();
        imem_img = '{32'h0000_0013, 32'h0010_0093};
        dmem_img.delete();
        load_and_check(0, "instr_only");
    endtask

    task automatic test_data_only();
        do_reset();
        imem_img.delete();
        dmem_img = '{64'h1122_3344_5566_7788};
        load_and_check(0, "data_only");
    endtask

    task automatic test_overflow();
        int bad = 0;
        int ready_seen = 0;
        do_reset();
        send_count(513, 0);
        rx_data = 8'hAA;
        rx_valid = 1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (wen_ext || wen_ext_2 || cpu_enable) bad++;
            if (rx_ready) ready_seen++;
        end
        rx_valid = 0;
        checks++;
        if (bad !== 0 || ready_seen !== 0) begin
            errors++;
            $display("FAIL imem_overflow_quiet: got bad=%0d ready=%0d required 0 0", bad, ready_seen);
        end
        checks++;
        if (error !== 1'b1 || cpu_enable !== 1'b0) begin
            errors++;
            $display("FAIL imem_overflow_flags: got error=%0b en=%0b required 1 0", error, cpu_enable);
        end
        do_reset();
        send_count(0, 0);
        send_count(1025, 0);
        rx_valid = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (error !== 1'b1 || cpu_enable !== 1'b0 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL dmem_overflow: got error=%0b en=%0b ready=%0b required 1 0 0",
                     error, cpu_enable, rx_ready);
        end
    endtask

    task automatic test_gaps();
        imem_img = '{$urandom, $urandom, $urandom};
        dmem_img = '{{$urandom, $urandom}, {$urandom, $urandom}};
        do_reset();
        load_and_check(0, "gap_free");
        do_reset();
        load_and_check(5, "gapped");
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        do_reset();
        w = $urandom;
        send_count(2, 0);
        for (int k = 0; k < 3; k++) send_byte(w[8*k +: 8], 0);
        rx_data = w[31:24];
        rx_valid = 1;
        rst = 1;
        @(negedge clk);
        rst = 0;
        rx_valid = 0;
        checks++;
        if ({wen_ext, wen_ext_2, cpu_enable, error} !== 4'b0 || addr_ext !== 64'b0 || wdata_ext !== 32'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got wen=%0b wen2=%0b en=%0b err=%0b addr=%h data=%h required all 0",
                     wen_ext, wen_ext_2, cpu_enable, error, addr_ext, wdata_ext);
        end
        @(negedge clk);
        checks++;
        if (ia_q.size() !== 0) begin
            errors++;
            $display("FAIL mid_reset_strobe: got %0d writes required 0", ia_q.size());
        end
        clear_obs();
        imem_img = '{$urandom, $urandom};
        dmem_img = '{{$urandom, $urandom}};
        load_and_check(2, "after_reset");
    endtask

    task automatic test_run_ignore();
        int ready_seen = 0;
        int strobes = 0;
        do_reset();
        imem_img = '{$urandom};
        dmem_img = '{{$urandom, $urandom}};
        load_and_check(1, "pre_run");
        rx_valid = 1;
        for (int t = 0; t < 20; t++) begin
            rx_data = 8'($urandom);
            @(negedge clk);
            if (rx_ready) ready_seen++;
            if (wen_ext || wen_ext_2) strobes++;
        end
        rx_valid = 0;
        checks++;
        if (ready_seen !== 0 || strobes !== 0 || cpu_enable !== 1'b1) begin
            errors++;
            $display("FAIL run_ignore: got ready=%0d strobes=%0d en=%0b required 0 0 1",
                     ready_seen, strobes, cpu_enable);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        imem_img.delete();
        for (int i = 0; i < 512; i++) imem_img.push_back($urandom);
        dmem_img = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
        load_and_check(0, "full_imem");
    endtask

    initial begin
        test_reset();
        test_instr_only();
        test_data_only();
        test_overflow();
        test_gaps();
        test_reset_mid();
        test_run_ignore();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
